in_port_unit: RTL and testbench

- Input-port side of the CPU's I/O pair; handles the `in` instruction path, the opposite direction of the `out`/OutPort path.
- An external device pushes 32-bit words through a valid/ready handshake into a small FIFO.
- During the `in` instruction, control asserts Inportout. The block then drives the FIFO head onto the bus-mux input and pops exactly one word per assertion.

---
 rtl/cpu_defs_pkg.sv | 11 +
 rtl/in_port_if.sv | 26 ++
 rtl/in_port_unit_fifo.sv | 59 +++++
 rtl/in_port_unit.sv | 72 +++++++
 tb/tb_in_port_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: bus word type and input-port FIFO geometry.
package cpu_defs;

   localparam int unsigned DATA_WIDTH   = 32;
   localparam int unsigned IN_DEPTH     = 4;
   localparam int unsigned IN_PTR_WIDTH = 2;
   localparam int unsigned IN_CNT_WIDTH = IN_PTR_WIDTH + 1;

   typedef logic [DATA_WIDTH-1:0] word_t;

endpackage : cpu_defs

// File: rtl/in_port_if.sv
// Device handshake and bus-side signals of the input port.
interface in_port_if;
   import cpu_defs::*;

   word_t                   dev_data;
   logic                    dev_valid;
   logic                    dev_ready;
   logic                    Inportout;
   word_t                   InPort_data;
   logic                    InPort_empty;
   logic [IN_CNT_WIDTH-1:0] InPort_count;
   logic                    InPort_underflow;

   // Device / control-unit side
   modport master (
      output dev_data, dev_valid, Inportout,
      input  dev_ready, InPort_data, InPort_empty, InPort_count, InPort_underflow
   );

   // Input-port block side
   modport slave (
      input  dev_data, dev_valid, Inportout,
      output dev_ready, InPort_data, InPort_empty, InPort_count, InPort_underflow
   );

endinterface : in_port_if

// File: rtl/in_port_unit_fifo.sv
// Small synchronous FIFO: storage, wrapping pointers and an occupancy count.
module sync_fifo
   import cpu_defs::*;
#(
   parameter int unsigned DEPTH     = IN_DEPTH,
   parameter int unsigned PTR_WIDTH = IN_PTR_WIDTH
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               push,
   input  logic               pop,
   input  word_t              wr_data,
   output word_t              rd_data,
   output logic [PTR_WIDTH:0] count,
   output logic [PTR_WIDTH:0] count_next_c,
   output logic               full_c,
   output logic               empty_c
);

   localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

   word_t                mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;

   // Occupancy after this edge; callers must not push when full or pop when empty
   always_comb begin
      count_next_c = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
   end

   assign full_c  = (count == CNT_WIDTH'(DEPTH));
   assign empty_c = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage write; contents need no reset
   always_ff @(posedge clock) begin
      if (push && !clear) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers and count; clear overrides any push or pop in the same cycle
   always_ff @(posedge clock) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         count <= count_next_c;
      end
   end

endmodule : sync_fifo

// File: rtl/in_port_unit.sv
// Input port of the CPU I/O pair: device words queue in a FIFO and one word
// is popped onto the bus mux per rising edge of the Inportout strobe.
module in_port_unit
   import cpu_defs::*;
(
   input  logic        clock,
   input  logic        clear,
   in_port_if.slave    port
);

   logic                    strobe_d;
   logic                    ready_q;
   logic                    underflow_q;
   logic                    pop_req_c;
   logic                    push_c;
   logic                    pop_c;
   logic                    full_c;
   logic                    empty_c;
   word_t                   head;
   logic [IN_CNT_WIDTH-1:0] count;
   logic [IN_CNT_WIDTH-1:0] count_next_c;

   // A held strobe pops once; a word is only popped when one is present
   assign pop_req_c = port.Inportout & ~strobe_d;
   assign push_c    = port.dev_valid & ready_q & ~full_c;
   assign pop_c     = pop_req_c & ~empty_c;

   sync_fifo #(
      .DEPTH     (IN_DEPTH),
      .PTR_WIDTH (IN_PTR_WIDTH)
   ) u_fifo (
      .clock        (clock),
      .clear        (clear),
      .push         (push_c),
      .pop          (pop_c),
      .wr_data      (port.dev_data),
      .rd_data      (head),
      .count        (count),
      .count_next_c (count_next_c),
      .full_c       (full_c),
      .empty_c      (empty_c)
   );

   // Strobe history, registered ready and sticky underflow flag
   always_ff @(posedge clock) begin
      if (clear) begin
         strobe_d    <= 1'b0;
         ready_q     <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         strobe_d <= port.Inportout;
         ready_q  <= (count_next_c != IN_CNT_WIDTH'(IN_DEPTH));
         if (pop_req_c && empty_c) begin
            underflow_q <= 1'b1;
         end
      end
   end

   // Bus mux input is zero unless the strobe is up and a word is held
   always_comb begin
      port.InPort_data = '0;
      if (port.Inportout && !empty_c) begin
         port.InPort_data = head;
      end
   end

   assign port.dev_ready        = ready_q;
   assign port.InPort_empty     = empty_c;
   assign port.InPort_count     = count;
   assign port.InPort_underflow = underflow_q;

endmodule : in_port_unit

// File: tb/tb_in_port_unit.sv
// Directed, table-driven bench for the input-port unit.
module tb_in_port_unit;
   import cpu_defs::*;

   logic clock = 1'b0;
   logic clear;
   int   errors = 0;
   int   checks = 0;

   in_port_if bus ();

   in_port_unit dut (
      .clock (clock),
      .clear (clear),
      .port  (bus)
   );

   always #5 clock = ~clock;

   // One cycle of stimulus: inputs, bus data during the cycle, state after the edge
   typedef struct {
      logic        clr;
      logic        v;
      logic [31:0] d;
      logic        io;
      logic [31:0] ed;
      logic [2:0]  ec;
      logic        er;
      logic        ee;
      logic        eu;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic clr, input logic v, input logic [31:0] d,
                      input logic io, input logic [31:0] ed, input logic [2:0] ec,
                      input logic er, input logic ee, input logic eu);
      vec_t t;
      t.clr = clr; t.v = v; t.d = d; t.io = io; t.ed = ed;
      t.ec = ec; t.er = er; t.ee = ee; t.eu = eu;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;

      //   clr v  d             io ed            ec ready empty uf
      // reset held two cycles, then first cycle after release
      add(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
      add(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);
      // single word push then one-cycle strobe
      add(0, 1, 32'hA5,       0, 32'h0,        1, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'hA5,       0, 1, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);
      // fill to full; fifth word refused
      add(0, 1, 32'h11,       0, 32'h0,        1, 1, 0, 0);
      add(0, 1, 32'h22,       0, 32'h0,        2, 1, 0, 0);
      add(0, 1, 32'h33,       0, 32'h0,        3, 1, 0, 0);
      add(0, 1, 32'h44,       0, 32'h0,        4, 0, 0, 0);
      add(0, 1, 32'h55,       0, 32'h0,        4, 0, 0, 0);
      add(0, 1, 32'h55,       1, 32'h11,       3, 1, 0, 0);
      add(0, 0, 32'h0,        0, 32'h0,        3, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h22,       2, 1, 0, 0);
      add(0, 0, 32'h0,        0, 32'h0,        2, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h33,       1, 1, 0, 0);
      add(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h44,       0, 1, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);
      // strobe held three cycles pops once
      add(0, 1, 32'h66,       0, 32'h0,        1, 1, 0, 0);
      add(0, 1, 32'h77,       0, 32'h0,        2, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h66,       1, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h77,       1, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h77,       1, 1, 0, 0);
      add(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0);
      add(0, 0, 32'h0,        1, 32'h77,       0, 1, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);
      // strobe on empty sets sticky underflow; only clear drops it
      add(0, 0, 32'h0,        1, 32'h0,        0, 1, 1, 1);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1);
      add(0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 1, 0, 1);
      add(0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 1, 1, 1);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 1);
      add(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);
      // simultaneous push and pop at count 2
      add(0, 1, 32'h10,       0, 32'h0,        1, 1, 0, 0);
      add(0, 1, 32'h20,       0, 32'h0,        2, 1, 0, 0);
      add(0, 1, 32'h30,       1, 32'h10,       2, 1, 0, 0);
      add(0, 0, 32'h0,        0, 32'h0,        2, 1, 0, 0);
      add(0, 1, 32'h40,       0, 32'h0,        3, 1, 0, 0);
      // clear in the middle of a strobe with a push offered
      add(1, 1, 32'h50,       1, 32'h20,       0, 0, 1, 0);
      add(0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 0);

      foreach (vecs[i]) begin
         clear         = vecs[i].clr;
         bus.dev_valid = vecs[i].v;
         bus.dev_data  = vecs[i].d;
         bus.Inportout = vecs[i].io;
         #1;
         check("data", i, bus.InPort_data, vecs[i].ed);
         @(posedge clock);
         #1;
         check("count", i, 32'(bus.InPort_count), 32'(vecs[i].ec));
         check("ready", i, 32'(bus.dev_ready), 32'(vecs[i].er));
         check("empty", i, 32'(bus.InPort_empty), 32'(vecs[i].ee));
         check("underflow", i, 32'(bus.InPort_underflow), 32'(vecs[i].eu));
      end

      // Fill while ready stays high, bounded by a cycle budget
      clear         = 1'b0;
      bus.Inportout = 1'b0;
      bus.dev_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.dev_ready) break;
         bus.dev_data = 32'h100 + 32'(n);
         @(posedge clock);
         #1;
         n++;
      end
      bus.dev_valid = 1'b0;
      check("fill_words", 0, 32'(n), 32'd4);
      check("fill_count", 0, 32'(bus.InPort_count), 32'd4);

      // Drain in order with one-high/one-low strobes
      for (int k = 0; k < 4; k++) begin
         bus.Inportout = 1'b1;
         #1;
         check("drain_data", k, bus.InPort_data, 32'h100 + 32'(k));
         @(posedge clock);
         #1;
         bus.Inportout = 1'b0;
         @(posedge clock);
         #1;
      end
      check("drain_empty", 0, 32'(bus.InPort_empty), 32'd1);
      check("drain_underflow", 0, 32'(bus.InPort_underflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_in_port_unit
